// File: rtl/mux_pkg.sv
// mux_pkg: shared constants, mode encodings and select-width helper for mux_rr_nto1.
package mux_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_N      = 4;
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int selw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational grant over req, searching from ptr (round-robin) or from 0 (fixed).
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);
    always_comb begin
        int c;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = mode ? k : (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                grant[c] = 1'b1;
                idx      = SELW'(c);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N-to-1 arbitrated mux with a single registered output stage.
module mux_rr_nto1
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int MODE  = MODE_RR,
    localparam int SELW = selw(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);
    logic [SELW-1:0] ptr;
    logic [N-1:0]    grant;
    logic [SELW-1:0] gidx;
    logic            load;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req  (in_valid),
        .ptr  (ptr),
        .mode (MODE == MODE_FIXED),
        .grant(grant),
        .idx  (gidx)
    );

    assign load = !out_valid || out_ready;
    // gated by rst_n so no channel sees an accept while reset is held
    assign in_ready = (load && rst_n) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= |in_valid;
            if (|in_valid) begin
                out_data <= in_data[int'(gidx)*WIDTH +: WIDTH];
                out_sel  <= gidx;
                if (MODE == MODE_RR)
                    ptr <= (int'(gidx) == N-1) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb_mux_rr_nto1: directed vectors for round-robin and fixed-priority instances.
module tb_mux_rr_nto1;
    logic        clk = 0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] d [4];
    logic [127:0] in_data;
    logic        out_ready;
    logic [3:0]  rdy_rr, rdy_fx;
    logic        ov_rr, ov_fx;
    logic [31:0] od_rr, od_fx;
    logic [1:0]  os_rr, os_fx;
    int vectors = 0;
    int miscompares = 0;

    assign in_data = {d[3], d[2], d[1], d[0]};
    always #5 clk = ~clk;

    mux_rr_nto1 #(.WIDTH(32), .N(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
        .out_ready(out_ready));

    mux_rr_nto1 #(.WIDTH(32), .N(4), .MODE(1)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_fx), .out_valid(ov_fx), .out_data(od_fx), .out_sel(os_fx),
        .out_ready(out_ready));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [31:0] dat);
        chk({tag, "_valid"}, 64'(ov_rr), 64'(v));
        chk({tag, "_sel"}, 64'(os_rr), 64'(s));
        chk({tag, "_data"}, 64'(od_rr), 64'(dat));
    endtask

    initial begin
        logic [1:0] seq [5];
        logic [31:0] chan [4];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        chan = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
        for (int i = 0; i < 4; i++) d[i] = chan[i];
        in_valid = 4'b1111;
        out_ready = 1;
        rst_n = 0;
        tick();
        tick();
        chk_out("reset", 0, 0, 32'h0);
        chk("reset_ready_rr", 64'(rdy_rr), 64'h0);
        chk("reset_ready_fx", 64'(rdy_fx), 64'h0);

        rst_n = 1;
        #1;
        chk("rr_first_ready", 64'(rdy_rr), 64'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("rr_seq%0d", i), 1, seq[i], chan[seq[i]]);
        end

        d[1] = 32'h12345678;
        tick();
        chk_out("bp_load", 1, 1, 32'h12345678);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_ready%0d", i), 64'(rdy_rr), 64'h0);
            tick();
            chk_out($sformatf("bp_hold%0d", i), 1, 1, 32'h12345678);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", 64'(rdy_rr), 64'b0100);
        tick();
        chk_out("bp_release", 1, 2, 32'hCCCCCCCC);

        in_valid = 4'b0101;
        #1;
        chk("wrap_ready", 64'(rdy_rr), 64'b0001);
        tick();
        chk_out("wrap_ch0", 1, 0, 32'hAAAAAAAA);
        tick();
        chk_out("wrap_ch2", 1, 2, 32'hCCCCCCCC);
        in_valid = 4'b0000;
        tick();
        chk_out("drain", 0, 2, 32'hCCCCCCCC);

        in_valid = 4'b0010;
        d[1] = 32'h87654321;
        tick();
        chk_out("mid_load", 1, 1, 32'h87654321);
        out_ready = 0;
        tick();
        chk_out("mid_stall", 1, 1, 32'h87654321);
        #2;
        rst_n = 0;
        #1;
        chk_out("mid_reset", 0, 0, 32'h0);
        chk("mid_reset_ready", 64'(rdy_rr), 64'h0);
        tick();
        rst_n = 1;
        out_ready = 1;
        in_valid = 4'b1111;
        tick();
        chk_out("post_reset", 1, 0, 32'hAAAAAAAA);

        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fx_ready%0d", i), 64'(rdy_fx), 64'b0010);
            tick();
            chk($sformatf("fx_sel%0d", i), 64'(os_fx), 64'd1);
            chk($sformatf("fx_valid%0d", i), 64'(ov_fx), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
